// File: rtl/effect_sample_feeder.sv
// rtl/effect_sample_feeder.sv - pops ADC samples and presents dry and clipped versions to the mixer
// Six-state Moore handshake: one FIFO read, one presented sample, one acknowledge per sample.

module effect_sample_feeder #(
   parameter int data_width = 16,
   parameter int clip_level = 8192
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_fifo_empty,
   input  logic [data_width-1:0] i_fifo_data,
   output logic                  o_fifo_rd,
   input  logic                  i_read_ready,
   input  logic                  i_read_done,
   output logic                  o_dv,
   output logic [data_width-1:0] o_data_sw0,
   output logic [data_width-1:0] o_data_sw1,
   output logic                  o_clipped
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      PROCESS,
      PRESENT,
      RELEASE
   } state_t;

   localparam logic signed [data_width-1:0] clip_pos = data_width'(clip_level);
   localparam logic signed [data_width-1:0] clip_neg = -clip_pos;

   state_t                       state;
   state_t                       state_nxt;
   logic signed [data_width-1:0] sample;
   logic signed [data_width-1:0] sat_data;
   logic                         sat_flag;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         sample     <= '0;
         o_data_sw0 <= '0;
         o_data_sw1 <= '0;
         o_clipped  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == CAPTURE) begin
            sample <= $signed(i_fifo_data);
         end
         // Outputs move only on the PROCESS-exit edge so they stay valid after o_dv falls
         if (state == PROCESS && i_read_ready) begin
            o_data_sw0 <= sample;
            o_data_sw1 <= sat_data;
            o_clipped  <= sat_flag;
         end
      end
   end

   always_comb begin
      sat_data = sample;
      sat_flag = 1'b0;
      if (sample > clip_pos) begin
         sat_data = clip_pos;
         sat_flag = 1'b1;
      end else if (sample < clip_neg) begin
         sat_data = clip_neg;
         sat_flag = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!i_fifo_empty) state_nxt = FETCH;
         FETCH:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = PROCESS;
         PROCESS: if (i_read_ready) state_nxt = PRESENT;
         PRESENT: if (i_read_done) state_nxt = RELEASE;
         // Waiting for done to fall keeps a long acknowledge from consuming the next sample
         RELEASE: if (!i_read_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign o_fifo_rd = (state == FETCH);
   assign o_dv      = (state == PRESENT);

endmodule

// File: tb/tb_effect_sample_feeder.sv
// tb/tb_effect_sample_feeder.sv - directed scoreboard bench for effect_sample_feeder
// A small FIFO model feeds the DUT; expected outputs are queued when samples are pushed.

module tb_effect_sample_feeder;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               i_fifo_empty;
   logic        [15:0] i_fifo_data = '0;
   logic               o_fifo_rd;
   logic               i_read_ready;
   logic               i_read_done;
   logic               o_dv;
   logic        [15:0] o_data_sw0;
   logic        [15:0] o_data_sw1;
   logic               o_clipped;

   logic        [15:0] fifo_mem [64];
   int                 push_count = 0;
   int                 pop_count = 0;
   int                 cyc = 0;
   int                 rd_count = 0;
   int                 rd_cyc = 0;
   int                 dv_cyc = 0;
   int                 errors = 0;
   int                 checks = 0;
   logic        [32:0] exp_q [$];

   effect_sample_feeder #(
      .data_width(16),
      .clip_level(8192)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .i_fifo_empty(i_fifo_empty),
      .i_fifo_data(i_fifo_data),
      .o_fifo_rd(o_fifo_rd),
      .i_read_ready(i_read_ready),
      .i_read_done(i_read_done),
      .o_dv(o_dv),
      .o_data_sw0(o_data_sw0),
      .o_data_sw1(o_data_sw1),
      .o_clipped(o_clipped)
   );

   always #5 clk = ~clk;

   assign i_fifo_empty = (push_count == pop_count);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (o_fifo_rd && push_count != pop_count) begin
         i_fifo_data <= fifo_mem[pop_count % 64];
         pop_count   <= pop_count + 1;
      end
   end

   always @(negedge clk) begin
      if (o_fifo_rd) begin
         rd_count <= rd_count + 1;
         rd_cyc   <= cyc;
      end
   end

   function automatic logic [32:0] model(input logic [15:0] x);
      int v;
      int s;
      logic c;
      v = int'($signed(x));
      s = v;
      c = 1'b0;
      if (v > 8192) begin
         s = 8192;
         c = 1'b1;
      end else if (v < -8192) begin
         s = -8192;
         c = 1'b1;
      end
      return {c, s[15:0], x};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_sample(input logic [15:0] x);
      fifo_mem[push_count % 64] = x;
      push_count++;
      exp_q.push_back(model(x));
   endtask

   task automatic wait_dv(input string tag, input int budget);
      logic [32:0] e;
      int n;
      n = 0;
      while (!o_dv && n < budget) begin
         @(negedge clk);
         n++;
      end
      dv_cyc = cyc;
      check({tag, "_dv_seen"}, {31'd0, o_dv}, 32'd1);
      if (o_dv) begin
         if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check({tag, "_sw0"}, {16'd0, o_data_sw0}, {16'd0, e[15:0]});
            check({tag, "_sw1"}, {16'd0, o_data_sw1}, {16'd0, e[31:16]});
            check({tag, "_clipped"}, {31'd0, o_clipped}, {31'd0, e[32]});
         end
      end
   endtask

   task automatic ack(input int hold);
      i_read_done = 1'b1;
      repeat (hold) @(negedge clk);
      i_read_done = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int rd0;
      logic [15:0] sw0_hold;
      logic [15:0] sw1_hold;
      logic        dv_seen;
      logic        rd_seen;
      logic        stable;

      reset_n      = 1'b0;
      i_read_ready = 1'b1;
      i_read_done  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_fifo_rd", {31'd0, o_fifo_rd}, 32'd0);
      check("rst_dv", {31'd0, o_dv}, 32'd0);
      check("rst_clipped", {31'd0, o_clipped}, 32'd0);
      check("rst_sw0", {16'd0, o_data_sw0}, 32'd0);
      check("rst_sw1", {16'd0, o_data_sw1}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Pass-through and latency
      rd0 = rd_count;
      push_sample(16'h1234);
      wait_dv("pass", 20);
      check("pass_latency", dv_cyc - rd_cyc, 32'd3);
      check("pass_one_rd", rd_count - rd0, 32'd1);
      ack(1);
      check("pass_dv_low", {31'd0, o_dv}, 32'd0);

      // Clipping at both rails and unclipped boundaries
      push_sample(16'h7FFF);
      push_sample(16'h8000);
      push_sample(16'h2000);
      push_sample(16'hE000);
      push_sample(16'h2001);
      push_sample(16'hDFFF);
      for (int i = 0; i < 6; i++) begin
         wait_dv($sformatf("clip%0d", i), 20);
         ack(1);
      end

      // Backpressure in PROCESS
      i_read_ready = 1'b0;
      sw0_hold = o_data_sw0;
      sw1_hold = o_data_sw1;
      rd0 = rd_count;
      push_sample(16'h0100);
      dv_seen = 1'b0;
      stable = 1'b1;
      repeat (24) begin
         @(negedge clk);
         dv_seen = dv_seen | o_dv;
         stable = stable & (o_data_sw0 == sw0_hold) & (o_data_sw1 == sw1_hold);
      end
      check("bp_one_rd", rd_count - rd0, 32'd1);
      check("bp_dv_low", {31'd0, dv_seen}, 32'd0);
      check("bp_stable", {31'd0, stable}, 32'd1);
      i_read_ready = 1'b1;
      @(negedge clk);
      check("bp_dv_next", {31'd0, o_dv}, 32'd1);
      wait_dv("bp", 2);
      ack(1);
      check("bp_hold_after", {16'd0, o_data_sw0}, 32'h0100);

      // Long acknowledge must consume exactly one sample
      rd0 = rd_count;
      push_sample(16'h0AAA);
      push_sample(16'hF555);
      wait_dv("long_a", 20);
      i_read_done = 1'b1;
      @(negedge clk);
      check("long_dv_drop", {31'd0, o_dv}, 32'd0);
      dv_seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         dv_seen = dv_seen | o_dv;
      end
      check("long_no_rd", rd_count - rd0, 32'd1);
      check("long_no_dv", {31'd0, dv_seen}, 32'd0);
      i_read_done = 1'b0;
      wait_dv("long_b", 20);
      ack(1);
      check("long_two_rd", rd_count - rd0, 32'd2);

      // Empty FIFO
      rd0 = rd_count;
      dv_seen = 1'b0;
      repeat (50) begin
         @(negedge clk);
         dv_seen = dv_seen | o_dv;
      end
      check("empty_no_rd", rd_count - rd0, 32'd0);
      check("empty_no_dv", {31'd0, dv_seen}, 32'd0);
      push_sample(16'h0042);
      #1;
      rd_seen = o_fifo_rd;
      check("empty_rd_not_yet", {31'd0, rd_seen}, 32'd0);
      @(negedge clk);
      check("empty_rd_second_edge", {31'd0, o_fifo_rd}, 32'd1);
      wait_dv("empty", 20);
      ack(1);

      // Asynchronous reset while presenting
      push_sample(16'h7000);
      wait_dv("rst_mid", 20);
      #2;
      reset_n = 1'b0;
      #1;
      check("amid_dv", {31'd0, o_dv}, 32'd0);
      check("amid_rd", {31'd0, o_fifo_rd}, 32'd0);
      check("amid_clipped", {31'd0, o_clipped}, 32'd0);
      check("amid_sw0", {16'd0, o_data_sw0}, 32'd0);
      check("amid_sw1", {16'd0, o_data_sw1}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      push_sample(16'hC000);
      wait_dv("after_rst", 20);
      ack(1);

      check("sb_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
